// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Requester and memory-side signals of the data-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MASK_W = 4
);
    logic              m0_req,    m1_req;
    logic              m0_we,     m1_we;
    logic [MASK_W-1:0] m0_wmask,  m1_wmask;
    logic [ADDR_W-1:0] m0_a,      m1_a;
    logic [DATA_W-1:0] m0_wd,     m1_wd;
    logic              m0_lock,   m1_lock;
    logic              m0_gnt,    m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rd,     m1_rd;
    logic              mem_we;
    logic [MASK_W-1:0] mem_wmask;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    // The arbiter itself
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_wmask, m1_wmask,
        input  m0_a, m1_a, m0_wd, m1_wd, m0_lock, m1_lock, mem_rd,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rd, m1_rd,
        output mem_we, mem_wmask, mem_a, mem_wd
    );

    // The surrounding requesters and memory
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_wmask, m1_wmask,
        output m0_a, m1_a, m0_wd, m1_wd, m0_lock, m1_lock, mem_rd,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rd, m1_rd,
        input  mem_we, mem_wmask, mem_a, mem_wd
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Two-requester arbiter for the memory data port with bus
//               locking, lock timeout and read-data routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MASK_W     = 4,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dmem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam int                CNT_W      = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(LOCK_MAX - 1);

    state_t              r_state, w_state_nxt;
    logic                r_last_gnt, w_last_gnt_nxt;
    logic [CNT_W-1:0]    r_lock_cnt, w_lock_cnt_nxt;
    logic                w_gnt0, w_gnt1;
    logic                w_rd_issue;
    logic [MASK_W-1:0]   w_wmask;
    logic [ADDR_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_wd;
    logic                w_we;
    logic [RD_LATENCY-1:0] r_tag_v;
    logic [RD_LATENCY-1:0] r_tag_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_gnt0         = 1'b0;
        w_gnt1         = 1'b0;
        w_state_nxt    = r_state;
        w_last_gnt_nxt = r_last_gnt;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    // Round-robin favours whoever was not granted last
                    if ((FIXED_PRIO != 0) || r_last_gnt) w_gnt0 = 1'b1;
                    else                                 w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = bus.m0_req;
                    w_gnt1 = bus.m1_req;
                end
                if ((w_gnt0 && bus.m0_lock) || (w_gnt1 && bus.m1_lock)) begin
                    w_state_nxt    = w_gnt0 ? LOCK0 : LOCK1;
                    w_lock_cnt_nxt = '0;
                end
            end
            LOCK0: begin
                w_gnt0 = bus.m0_req;
                if (!bus.m0_lock) begin
                    w_state_nxt = IDLE;
                end else if (r_lock_cnt == c_cnt_last) begin
                    w_state_nxt    = IDLE;
                    w_last_gnt_nxt = 1'b0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            LOCK1: begin
                w_gnt1 = bus.m1_req;
                if (!bus.m1_lock) begin
                    w_state_nxt = IDLE;
                end else if (r_lock_cnt == c_cnt_last) begin
                    w_state_nxt    = IDLE;
                    w_last_gnt_nxt = 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
        if (w_gnt0)      w_last_gnt_nxt = 1'b0;
        else if (w_gnt1) w_last_gnt_nxt = 1'b1;
    end

    always_comb begin
        w_we    = 1'b0;
        w_wmask = '0;
        w_a     = '0;
        w_wd    = '0;
        if (w_gnt0) begin
            w_we    = bus.m0_we;
            w_wmask = bus.m0_we ? bus.m0_wmask : '0;
            w_a     = bus.m0_a;
            w_wd    = bus.m0_wd;
        end else if (w_gnt1) begin
            w_we    = bus.m1_we;
            w_wmask = bus.m1_we ? bus.m1_wmask : '0;
            w_a     = bus.m1_a;
            w_wd    = bus.m1_wd;
        end
    end

    assign w_rd_issue    = (w_gnt0 && !bus.m0_we) || (w_gnt1 && !bus.m1_we);
    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.mem_we    = w_we;
    assign bus.mem_wmask = w_wmask;
    assign bus.mem_a     = w_a;
    assign bus.mem_wd    = w_wd;

    // Read tags travel alongside the memory latency; stage 0 holds the newest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_rd_issue;
            r_tag_id[0] <= w_gnt1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign bus.m0_rvalid = !reset && r_tag_v[RD_LATENCY-1] && !r_tag_id[RD_LATENCY-1];
    assign bus.m1_rvalid = !reset && r_tag_v[RD_LATENCY-1] &&  r_tag_id[RD_LATENCY-1];
    assign bus.m0_rd     = bus.mem_rd;
    assign bus.m1_rd     = bus.mem_rd;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed and randomized checks of two arbiter configurations
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    // Instance 0: round-robin, latency 1, short lock; instance 1: fixed, latency 2
    localparam int A_LAT = 1, A_FIX = 0, A_LMAX = 4;
    localparam int B_LAT = 2, B_FIX = 1, B_LMAX = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_req  [2][2];
    logic        s_we   [2][2];
    logic        s_lock [2][2];
    logic [3:0]  s_mask [2][2];
    logic [31:0] s_a    [2][2];
    logic [31:0] s_wd   [2][2];
    logic [31:0] s_mrd  [2];

    logic        o_gnt  [2][2];
    logic        o_rv   [2][2];
    logic [31:0] o_rd   [2][2];
    logic        o_mwe  [2];
    logic [3:0]  o_mmask[2];
    logic [31:0] o_ma   [2];
    logic [31:0] o_mwd  [2];

    dmem_port_arbiter_if ifa ();
    dmem_port_arbiter_if ifb ();

    assign ifa.m0_req = s_req[0][0];    assign ifa.m1_req = s_req[0][1];
    assign ifa.m0_we = s_we[0][0];      assign ifa.m1_we = s_we[0][1];
    assign ifa.m0_wmask = s_mask[0][0]; assign ifa.m1_wmask = s_mask[0][1];
    assign ifa.m0_a = s_a[0][0];        assign ifa.m1_a = s_a[0][1];
    assign ifa.m0_wd = s_wd[0][0];      assign ifa.m1_wd = s_wd[0][1];
    assign ifa.m0_lock = s_lock[0][0];  assign ifa.m1_lock = s_lock[0][1];
    assign ifa.mem_rd = s_mrd[0];
    assign ifb.m0_req = s_req[1][0];    assign ifb.m1_req = s_req[1][1];
    assign ifb.m0_we = s_we[1][0];      assign ifb.m1_we = s_we[1][1];
    assign ifb.m0_wmask = s_mask[1][0]; assign ifb.m1_wmask = s_mask[1][1];
    assign ifb.m0_a = s_a[1][0];        assign ifb.m1_a = s_a[1][1];
    assign ifb.m0_wd = s_wd[1][0];      assign ifb.m1_wd = s_wd[1][1];
    assign ifb.m0_lock = s_lock[1][0];  assign ifb.m1_lock = s_lock[1][1];
    assign ifb.mem_rd = s_mrd[1];

    assign o_gnt[0][0] = ifa.m0_gnt;    assign o_gnt[0][1] = ifa.m1_gnt;
    assign o_rv[0][0] = ifa.m0_rvalid;  assign o_rv[0][1] = ifa.m1_rvalid;
    assign o_rd[0][0] = ifa.m0_rd;      assign o_rd[0][1] = ifa.m1_rd;
    assign o_mwe[0] = ifa.mem_we;       assign o_mmask[0] = ifa.mem_wmask;
    assign o_ma[0] = ifa.mem_a;         assign o_mwd[0] = ifa.mem_wd;
    assign o_gnt[1][0] = ifb.m0_gnt;    assign o_gnt[1][1] = ifb.m1_gnt;
    assign o_rv[1][0] = ifb.m0_rvalid;  assign o_rv[1][1] = ifb.m1_rvalid;
    assign o_rd[1][0] = ifb.m0_rd;      assign o_rd[1][1] = ifb.m1_rd;
    assign o_mwe[1] = ifb.mem_we;       assign o_mmask[1] = ifb.mem_wmask;
    assign o_ma[1] = ifb.mem_a;         assign o_mwd[1] = ifb.mem_wd;

    dmem_port_arbiter #(.RD_LATENCY(A_LAT), .FIXED_PRIO(A_FIX), .LOCK_MAX(A_LMAX))
        dut_a (.clk(clk), .reset(rst), .bus(ifa));
    dmem_port_arbiter #(.RD_LATENCY(B_LAT), .FIXED_PRIO(B_FIX), .LOCK_MAX(B_LMAX))
        dut_b (.clk(clk), .reset(rst), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: actual=%h required=%h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int owner[2];        // -1 when unlocked, else locking requester
    int cnt[2];          // cycles spent in the current lock
    int last[2];         // most recently granted requester
    int pend[2][8];      // read responses due, by cycle mod 8: 0 none, 1 m0, 2 m1
    logic acc[2][2];
    int cyc = 0;
    bit started = 0;

    function automatic int lat(input int k);  return k == 0 ? A_LAT  : B_LAT;  endfunction
    function automatic int lmax(input int k); return k == 0 ? A_LMAX : B_LMAX; endfunction
    function automatic bit fix(input int k);  return k == 0 ? (A_FIX != 0) : (B_FIX != 0); endfunction

    function automatic int winner(input int k);
        if (rst) return -1;
        if (owner[k] >= 0) return s_req[k][owner[k]] ? owner[k] : -1;
        if (s_req[k][0] && s_req[k][1]) return (fix(k) || last[k] == 1) ? 0 : 1;
        if (s_req[k][0]) return 0;
        if (s_req[k][1]) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int w;
            w = winner(k);
            acc[k][0] = (w == 0);
            acc[k][1] = (w == 1);
            pend[k][cyc % 8] = 0;
            if (rst) begin
                owner[k] = -1; cnt[k] = 0; last[k] = 1;
                for (int j = 0; j < 8; j++) pend[k][j] = 0;
            end else begin
                if (w >= 0) begin
                    last[k] = w;
                    if (!s_we[k][w]) pend[k][(cyc + lat(k)) % 8] = w + 1;
                end
                if (owner[k] < 0) begin
                    if (w >= 0 && s_lock[k][w]) begin owner[k] = w; cnt[k] = 0; end
                end else if (!s_lock[k][owner[k]]) begin
                    owner[k] = -1;
                end else if (cnt[k] == lmax(k) - 1) begin
                    last[k] = owner[k]; owner[k] = -1;
                end else begin
                    cnt[k]++;
                end
            end
        end
        cyc++;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                int w, e;
                logic ewe;
                logic [3:0] emask;
                logic [31:0] ea, ewd;
                w = winner(k);
                e = rst ? 0 : pend[k][cyc % 8];
                ewe = 1'b0; emask = 4'h0; ea = 32'h0; ewd = 32'h0;
                if (w >= 0) begin
                    ewe = s_we[k][w]; emask = s_we[k][w] ? s_mask[k][w] : 4'h0;
                    ea = s_a[k][w];   ewd = s_wd[k][w];
                end
                chk("gnt0", k, o_gnt[k][0], w == 0);
                chk("gnt1", k, o_gnt[k][1], w == 1);
                chk("mem_we", k, o_mwe[k], ewe);
                chk("mem_wmask", k, o_mmask[k], emask);
                chk("mem_a", k, o_ma[k], ea);
                chk("mem_wd", k, o_mwd[k], ewd);
                chk("rvalid0", k, o_rv[k][0], e == 1);
                chk("rvalid1", k, o_rv[k][1], e == 2);
                if (e != 0) chk("rd", k, o_rd[k][e-1], s_mrd[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) begin
                s_req[k][m] = 1'b0; s_we[k][m] = 1'b0; s_lock[k][m] = 1'b0;
                s_mask[k][m] = 4'h0; s_a[k][m] = 32'h0; s_wd[k][m] = 32'h0;
            end
    endtask

    task automatic drv(input int k, input int m, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic lock);
        s_req[k][m] = req; s_we[k][m] = we; s_a[k][m] = a;
        s_wd[k][m] = wd;   s_mask[k][m] = 4'hF; s_lock[k][m] = lock;
    endtask

    task automatic rand_drive();
        for (int k = 0; k < 2; k++) begin
            s_mrd[k] = $urandom;
            for (int m = 0; m < 2; m++) begin
                if (s_req[k][m] && !acc[k][m]) continue;
                s_req[k][m]  = ($urandom_range(0, 99) < 55);
                s_we[k][m]   = 1'($urandom_range(0, 1));
                s_a[k][m]    = $urandom;
                s_wd[k][m]   = $urandom;
                s_mask[k][m] = 4'($urandom);
                s_lock[k][m] = (owner[k] == m) ? ($urandom_range(0, 9) < 8)
                                               : ($urandom_range(0, 9) < 2);
            end
        end
        rst = ($urandom_range(0, 249) == 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        s_mrd[0] = 32'h0; s_mrd[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            drv(k, 0, 1, 1, 32'h8, 32'h1, 0);
            drv(k, 1, 1, 1, 32'hC, 32'h2, 0);
        end
        step();
        @(negedge clk);
        chk("reset_gnt0", 0, o_gnt[0][0], 0);
        chk("reset_gnt1", 0, o_gnt[0][1], 0);
        chk("reset_gnt0", 1, o_gnt[1][0], 0);
        chk("reset_mem_we", 0, o_mwe[0], 0);
        chk("reset_mem_wmask", 0, o_mmask[0], 0);
        chk("reset_rvalid0", 1, o_rv[1][0], 0);

        // Continuous contention: round-robin alternates, fixed priority sticks to m0
        step();
        rst = 1'b0;
        idle_all();
        for (int k = 0; k < 2; k++) begin
            drv(k, 0, 1, 1, 32'h100, 32'h1111_1111, 0);
            drv(k, 1, 1, 1, 32'h200, 32'h2222_2222, 0);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("rr_gnt0", 0, o_gnt[0][0], (i % 2) == 0);
            chk("rr_gnt1", 0, o_gnt[0][1], (i % 2) == 1);
            chk("rr_mem_a", 0, o_ma[0], (i % 2) == 0 ? 32'h100 : 32'h200);
            chk("rr_mem_we", 0, o_mwe[0], 1);
            chk("rr_mem_wmask", 0, o_mmask[0], 4'hF);
            chk("fp_gnt0", 1, o_gnt[1][0], 1);
            chk("fp_gnt1", 1, o_gnt[1][1], 0);
        end

        // Single read with latency 1
        step();
        idle_all();
        drv(0, 0, 1, 0, 32'h10, 32'h0, 0);
        s_mrd[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_gnt0", 0, o_gnt[0][0], 1);
        chk("rd_mem_a", 0, o_ma[0], 32'h10);
        chk("rd_mem_we", 0, o_mwe[0], 0);
        step();
        idle_all();
        @(negedge clk);
        chk("rd_rvalid0", 0, o_rv[0][0], 1);
        chk("rd_data0", 0, o_rd[0][0], 32'hDEAD_BEEF);
        chk("rd_rvalid1", 0, o_rv[0][1], 0);

        // Lock held by m1 for four writes, then released
        step();
        idle_all();
        drv(1, 1, 1, 1, 32'h40, 32'hA0, 1);
        @(negedge clk);
        chk("lock_first_gnt1", 1, o_gnt[1][1], 1);
        for (int i = 1; i < 4; i++) begin
            step();
            drv(1, 1, 1, 1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 1);
            drv(1, 0, 1, 1, 32'h80, 32'hB0, 0);
            @(negedge clk);
            chk("lock_gnt1", 1, o_gnt[1][1], 1);
            chk("lock_gnt0", 1, o_gnt[1][0], 0);
            chk("lock_mem_a", 1, o_ma[1], 32'h40 + 32'(4 * i));
        end
        step();
        drv(1, 1, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("release_cycle_gnt0", 1, o_gnt[1][0], 0);
        step();
        @(negedge clk);
        chk("after_release_gnt0", 1, o_gnt[1][0], 1);
        chk("after_release_mem_a", 1, o_ma[1], 32'h80);

        // Lock timeout with LOCK_MAX = 4
        step();
        idle_all();
        drv(0, 1, 1, 1, 32'h300, 32'hC0, 1);
        @(negedge clk);
        chk("to_enter_gnt1", 0, o_gnt[0][1], 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            drv(0, 0, 1, 1, 32'h400, 32'hD0, 0);
            @(negedge clk);
            chk("to_hold_gnt1", 0, o_gnt[0][1], 1);
            chk("to_hold_gnt0", 0, o_gnt[0][0], 0);
        end
        step();
        @(negedge clk);
        chk("to_after_gnt0", 0, o_gnt[0][0], 1);
        chk("to_after_gnt1", 0, o_gnt[0][1], 0);
        chk("to_after_mem_a", 0, o_ma[0], 32'h400);

        // Reset while a latency-2 read is in flight
        step();
        idle_all();
        drv(1, 1, 1, 0, 32'h20, 32'h0, 0);
        @(negedge clk);
        chk("mr_gnt1", 1, o_gnt[1][1], 1);
        step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drv(k, 0, 1, 1, 32'h500, 32'h5, 0);
            drv(k, 1, 1, 1, 32'h600, 32'h6, 0);
        end
        @(negedge clk);
        chk("mr_rst_gnt0", 1, o_gnt[1][0], 0);
        chk("mr_rst_gnt1", 1, o_gnt[1][1], 0);
        chk("mr_rst_rvalid1", 1, o_rv[1][1], 0);
        chk("mr_rst_mem_we", 1, o_mwe[1], 0);
        chk("mr_rst_mem_wmask", 1, o_mmask[1], 0);
        chk("mr_rst_gnt0", 0, o_gnt[0][0], 0);
        chk("mr_rst_gnt1", 0, o_gnt[0][1], 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_dropped_rvalid1", 1, o_rv[1][1], 0);
        chk("mr_post_gnt0", 0, o_gnt[0][0], 1);
        chk("mr_post_gnt1", 0, o_gnt[0][1], 0);
        chk("mr_post_gnt0", 1, o_gnt[1][0], 1);

        step();
        idle_all();
        repeat (3000) begin
            step();
            rand_drive();
        end
        step();
        rst = 1'b0;
        idle_all();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data port of the dual-port instruction/data memory between two requesters.
- Requester 0 is the core data port. Requester 1 is a program-loader/debug master.
- Performs request/grant arbitration, optional bus locking with a timeout, and routing of read data back to the requester that issued each read.
- Sits between the core (and loader) and the memory's data-side port. The memory's instruction port is untouched.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, byte-address width.
- MASK_W, 4, write byte-mask width (DATA_W/8).
- RD_LATENCY, 1, cycles from read accept to read data on the memory port. Legal values: 1..2.
- FIXED_PRIO, 0. 0 = round-robin; 1 = requester 0 always wins.
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_req / m1_req  in  1  transaction request
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_wmask / m1_wmask  in  MASK_W  byte write mask
- m0_a / m1_a  in  ADDR_W  byte address
- m0_wd / m1_wd  in  DATA_W  write data
- m0_lock / m1_lock  in  1  request exclusive ownership after grant
- m0_gnt / m1_gnt  out  1  transaction accepted this cycle
- m0_rvalid / m1_rvalid  out  1  read data valid
- m0_rd / m1_rd  out  DATA_W  read data
- mem_we  out  1  memory write enable
- mem_wmask  out  MASK_W  memory write mask
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset:
  - State goes to IDLE; last_gnt = 1, so requester 0 wins the first contention.
  - Lock counter = 0; read-tag pipeline cleared.
  - All gnt, rvalid, mem_we and mem_wmask are 0 while reset is high.
  - Read responses still in flight when reset asserts are dropped; no rvalid is produced for them.
- Handshake:
  - A transaction is accepted in the cycle where mX_req && mX_gnt.
  - gnt is combinational from req and the registered state.
  - A requester holds req/we/a/wd/wmask/lock stable until gnt.
  - At most one gnt per cycle.
- Memory mux:
  - Granted requester's a/wd/wmask drive mem_*.
  - mem_we = accept && we.
  - mem_wmask = we ? wmask : 0.
  - With no grant: mem_we = 0, mem_wmask = 0, mem_a/mem_wd = 0.
- Reads:
  - On a read accept, tag {valid, id} enters an RD_LATENCY-deep shift register.
  - Exactly RD_LATENCY cycles later, m<id>_rvalid = 1 for one cycle with m<id>_rd = mem_rd.
  - The other requester's rvalid stays 0.
  - Back-to-back reads give back-to-back rvalids in issue order.
  - mX_rd is don't-care when rvalid = 0; drive mem_rd to both.
- Writes: complete in the accept cycle; no response.
- Arbitration in IDLE:
  - Single requester: it is granted.
  - Both requesting:
    - FIXED_PRIO = 1: requester 0 wins.
    - FIXED_PRIO = 0: the requester != last_gnt wins.
  - last_gnt updates on every accept.
- States: IDLE, LOCK0, LOCK1.
  - IDLE -> LOCKn: accept from n with mn_lock = 1; lock counter cleared.
  - In LOCKn:
    - Only n may be granted; the other requester waits.
    - Counter increments every cycle.
  - LOCKn -> IDLE, whichever comes first:
    - (a) a cycle where mn_lock = 0. The accept in that same cycle, if any, is still granted.
    - (b) counter reaches LOCK_MAX - 1: forced release at the end of that cycle.
  - After a forced release, last_gnt = n, so under round-robin the other requester wins the next contention.
- Simultaneous events:
  - A lock release and the other requester's req in the same cycle: the other requester is granted no earlier than the next cycle.
- Address/width: addresses are passed through unmodified; no alignment checks.

Test Plan:
- Single read: m0 read a=0x10 and mem returns 0xDEADBEEF, RD_LATENCY = 1 -> m0_gnt the same cycle, m0_rvalid = 1 with m0_rd = 0xDEADBEEF exactly one cycle later, m1_rvalid = 0.
- Contention, round-robin: m0 and m1 request continuously for 4 cycles after reset -> grants m0, m1, m0, m1; each write drives mem_we/mem_wmask = 0xF with the correct address.
- Fixed priority: FIXED_PRIO = 1, both requesting for 3 cycles -> m0 granted all 3, m1_gnt stays 0.
- Lock: m1 writes 4 words with m1_lock = 1, then deasserts lock, while m0 requests throughout -> m0_gnt = 0 during the lock, and m0 is granted the cycle after release.
- Lock timeout: LOCK_MAX = 4, m1 holds lock indefinitely and m0 requests -> forced release after 4 lock cycles; m0 granted next.
- Reset mid-read: m1 read accepted with RD_LATENCY = 2, reset asserted the next cycle -> no m1_rvalid; all outputs 0 during reset; first post-reset contention goes to m0.
